softmax_argmax: RTL and testbench
=================================

SOFTMAX_ARGMAX -- requirements
Module: softmax_argmax

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH_OUT, default 24, giving the width of one softmax output word.
REQ-002 The block SHALL have parameter IFM_SIZE, default 1000, giving the number of elements in one vector.
REQ-003 The block SHALL have parameter IDX_WIDTH, default 10, giving the element index width (IDX_WIDTH >= clog2(IFM_SIZE)).
REQ-004 The block SHALL have parameter SUM_WIDTH, default 34, giving the sum accumulator width (DATA_WIDTH_OUT + IDX_WIDTH).
REQ-005 The block SHALL have port clk1, input, 1 bit: the single clock; all logic on its rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-007 The block SHALL have port valid_data, input, 1 bit: softmax_out_final is valid this cycle.
REQ-008 The block SHALL have port softmax_out_final, input, DATA_WIDTH_OUT bits: unsigned softmax probability.
REQ-009 The block SHALL have port end_softmax, input, 1 bit: the upstream vector is complete.
REQ-010 The block SHALL have port result_ack, input, 1 bit: the consumer has taken the result.
REQ-011 The block SHALL have port argmax_idx, output, IDX_WIDTH bits: index of the maximum element.
REQ-012 The block SHALL have port argmax_val, output, DATA_WIDTH_OUT bits: value of the maximum element.
REQ-013 The block SHALL have port prob_sum, output, SUM_WIDTH bits: sum of all accepted elements.
REQ-014 The block SHALL have port elem_cnt, output, IDX_WIDTH+1 bits: number of elements accepted.
REQ-015 The block SHALL have the following status outputs, 1 bit each: result_valid, len_err, overrun, busy.

Function
REQ-016 The block SHALL implement FSM states IDLE, ACCUM and HOLD; busy SHALL be 1 whenever the state is not IDLE.
REQ-017 In IDLE, valid_data=1 SHALL load max=value, idx=0, sum=value and count=1, and move the FSM to ACCUM; end_softmax without valid_data in IDLE SHALL be ignored.
REQ-018 In ACCUM, each valid_data=1 cycle SHALL add the value to sum, increment count, and update max/idx only if value > max (strict compare, so ties keep the earliest index).
REQ-019 A vector SHALL close when the accepted element makes count == IFM_SIZE, or when end_softmax=1; a valid_data in the same cycle as end_softmax SHALL be included first.
REQ-020 On close, the block SHALL register all results, assert result_valid on the next cycle, and enter HOLD; latency is 1 cycle from the last accepted element.
REQ-021 len_err SHALL be 1 if count != IFM_SIZE at close, and 0 otherwise.
REQ-022 In HOLD, result_valid and all result outputs SHALL stay stable until the cycle result_ack=1; the next cycle SHALL be IDLE with result_valid=0 and results retained.
REQ-023 valid_data=1 in HOLD, including the result_ack cycle, SHALL be dropped and SHALL set overrun, which is sticky until reset.
REQ-024 result_ack outside HOLD SHALL be ignored.
REQ-025 The sum SHALL be unsigned and SHALL not overflow for IFM_SIZE elements of the maximum value.

Reset
REQ-026 rst=1 at a clock edge SHALL force IDLE and clear all outputs and internal registers to 0, including mid-ACCUM or mid-HOLD; any partial vector SHALL be discarded.
REQ-027 The first valid_data after rst is released SHALL be treated as element 0.

Configuration
REQ-028 When macro SOFTMAX_ARGMAX_SUM_EN is defined, the sum accumulator SHALL be built and prob_sum driven as specified.
REQ-029 When SOFTMAX_ARGMAX_SUM_EN is undefined, no accumulator SHALL be built and prob_sum SHALL be constant 0; all other behaviour SHALL be unchanged.

Verification
REQ-030 Feed 1000 elements with value=i (i=0..999) -> argmax_idx=999, argmax_val=999, prob_sum=499500, elem_cnt=1000, len_err=0, result_valid the cycle after element 999.
REQ-031 Feed 1000 elements all 0x400000 with a peak 0x7FFFFF at i=5 and i=700 -> argmax_idx=5, argmax_val=0x7FFFFF.
REQ-032 Feed 10 elements with end_softmax=1 alongside element 9 -> elem_cnt=10, len_err=1, result_valid next cycle.
REQ-033 Pulse valid_data with value 0xFFFFFF during HOLD -> overrun=1 and results unchanged; result_ack -> IDLE next cycle; the next vector is processed correctly.
REQ-034 Assert rst at element 500 -> all outputs 0 the next cycle; a following full vector gives correct results.
REQ-035 Rerun REQ-030 with SOFTMAX_ARGMAX_SUM_EN undefined -> prob_sum=0, all other outputs identical.

Source files
------------

// File: rtl/softmax_argmax.sv
// -----------------------------------------------------------------------------
// softmax_argmax
//
// Purpose:
//   Streams one vector of unsigned softmax probabilities and reports the index
//   and value of the largest element, the number of elements taken and
//   (optionally) their sum. Results are registered when the vector closes and
//   held, with result_valid, until the consumer acknowledges them.
//
// Optional feature:
//   SOFTMAX_ARGMAX_SUM_EN - when defined, the sum accumulator is built and
//   prob_sum reports the sum of the accepted elements. When undefined no
//   accumulator exists and prob_sum is tied to 0.
//
// Ports:
//   clk1              in   single clock, rising edge
//   rst               in   synchronous active-high reset
//   valid_data        in   softmax_out_final is valid this cycle
//   softmax_out_final in   [DATA_WIDTH_OUT] unsigned probability
//   end_softmax       in   upstream vector is complete
//   result_ack        in   consumer has taken the result
//   argmax_idx        out  [IDX_WIDTH] index of the maximum element
//   argmax_val        out  [DATA_WIDTH_OUT] value of the maximum element
//   prob_sum          out  [SUM_WIDTH] sum of accepted elements
//   elem_cnt          out  [IDX_WIDTH+1] number of accepted elements
//   result_valid      out  results are valid and held
//   len_err           out  closed vector length differed from IFM_SIZE
//   overrun           out  data arrived while a result was held (sticky)
//   busy              out  FSM is not IDLE
// -----------------------------------------------------------------------------
module softmax_argmax #(
  parameter int DATA_WIDTH_OUT = 24,
  parameter int IFM_SIZE       = 1000,
  parameter int IDX_WIDTH      = 10,
  parameter int SUM_WIDTH      = 34
) (
  input  logic                      clk1,
  input  logic                      rst,
  input  logic                      valid_data,
  input  logic [DATA_WIDTH_OUT-1:0] softmax_out_final,
  input  logic                      end_softmax,
  input  logic                      result_ack,
  output logic [IDX_WIDTH-1:0]      argmax_idx,
  output logic [DATA_WIDTH_OUT-1:0] argmax_val,
  output logic [SUM_WIDTH-1:0]      prob_sum,
  output logic [IDX_WIDTH:0]        elem_cnt,
  output logic                      result_valid,
  output logic                      len_err,
  output logic                      overrun,
  output logic                      busy
);

  localparam logic [IDX_WIDTH:0] FULL_CNT = (IDX_WIDTH+1)'(IFM_SIZE);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t state_reg, state_next;

  // Working accumulators for the vector in progress.
  logic [DATA_WIDTH_OUT-1:0] max_reg, max_next;
  logic [IDX_WIDTH-1:0]      idx_reg, idx_next;
  logic [IDX_WIDTH:0]        cnt_reg, cnt_next;

  // Held results.
  logic [DATA_WIDTH_OUT-1:0] res_val_reg;
  logic [IDX_WIDTH-1:0]      res_idx_reg;
  logic [IDX_WIDTH:0]        res_cnt_reg;
  logic                      result_valid_reg;
  logic                      len_err_reg;
  logic                      overrun_reg;

  // Candidate values if the current element is taken.
  logic                      first_elem;
  logic                      take;
  logic                      close;
  logic                      gt_max;
  logic [DATA_WIDTH_OUT-1:0] upd_max;
  logic [IDX_WIDTH-1:0]      upd_idx;
  logic [IDX_WIDTH:0]        upd_cnt;

  // Values latched into the result registers on close: the current element
  // is folded in first when it arrives together with end_softmax.
  logic [DATA_WIDTH_OUT-1:0] fin_max;
  logic [IDX_WIDTH-1:0]      fin_idx;
  logic [IDX_WIDTH:0]        fin_cnt;

  // ---------------------------------------------------------------------------
  // Element update arithmetic
  // ---------------------------------------------------------------------------
  always_comb begin
    first_elem = (state_reg == IDLE);
    // Strict compare keeps the earliest index on ties.
    gt_max     = (softmax_out_final > max_reg);
    if (first_elem) begin
      upd_max = softmax_out_final;
      upd_idx = '0;
      upd_cnt = (IDX_WIDTH+1)'(1);
    end else begin
      upd_max = gt_max ? softmax_out_final : max_reg;
      // Index of the new element equals the count before it is taken.
      upd_idx = gt_max ? cnt_reg[IDX_WIDTH-1:0] : idx_reg;
      upd_cnt = cnt_reg + (IDX_WIDTH+1)'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and control
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    take       = 1'b0;
    close      = 1'b0;
    case (state_reg)
      IDLE: begin
        // end_softmax alone is ignored here; with data it closes a
        // one-element vector.
        if (valid_data) begin
          take       = 1'b1;
          state_next = ACCUM;
          if ((upd_cnt == FULL_CNT) || end_softmax) begin
            close = 1'b1;
          end
        end
      end
      ACCUM: begin
        if (valid_data) begin
          take = 1'b1;
        end
        if ((valid_data && (upd_cnt == FULL_CNT)) || end_softmax) begin
          close = 1'b1;
        end
      end
      HOLD: begin
        if (result_ack) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
    if (close) begin
      state_next = HOLD;
    end
  end

  always_comb begin
    max_next = max_reg;
    idx_next = idx_reg;
    cnt_next = cnt_reg;
    if (take) begin
      max_next = upd_max;
      idx_next = upd_idx;
      cnt_next = upd_cnt;
    end
    fin_max = max_next;
    fin_idx = idx_next;
    fin_cnt = cnt_next;
  end

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk1) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Working accumulators
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk1) begin
    if (rst) begin
      max_reg <= '0;
      idx_reg <= '0;
      cnt_reg <= '0;
    end else begin
      max_reg <= max_next;
      idx_reg <= idx_next;
      cnt_reg <= cnt_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Result registers and status flags
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk1) begin
    if (rst) begin
      res_val_reg      <= '0;
      res_idx_reg      <= '0;
      res_cnt_reg      <= '0;
      result_valid_reg <= 1'b0;
      len_err_reg      <= 1'b0;
      overrun_reg      <= 1'b0;
    end else begin
      if (close) begin
        res_val_reg      <= fin_max;
        res_idx_reg      <= fin_idx;
        res_cnt_reg      <= fin_cnt;
        len_err_reg      <= (fin_cnt != FULL_CNT);
        result_valid_reg <= 1'b1;
      end else if ((state_reg == HOLD) && result_ack) begin
        result_valid_reg <= 1'b0;
      end
      // Data arriving while a result is held is dropped and flagged,
      // including on the acknowledge cycle.
      if ((state_reg == HOLD) && valid_data) begin
        overrun_reg <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Optional probability sum
  // ---------------------------------------------------------------------------
`ifdef SOFTMAX_ARGMAX_SUM_EN
  logic [SUM_WIDTH-1:0] sum_reg, sum_next;
  logic [SUM_WIDTH-1:0] res_sum_reg;
  logic [SUM_WIDTH-1:0] upd_sum;

  always_comb begin
    if (first_elem) begin
      upd_sum = SUM_WIDTH'(softmax_out_final);
    end else begin
      upd_sum = sum_reg + SUM_WIDTH'(softmax_out_final);
    end
    sum_next = take ? upd_sum : sum_reg;
  end

  always_ff @(posedge clk1) begin
    if (rst) begin
      sum_reg     <= '0;
      res_sum_reg <= '0;
    end else begin
      sum_reg <= sum_next;
      if (close) begin
        res_sum_reg <= sum_next;
      end
    end
  end

  assign prob_sum = res_sum_reg;
`else
  assign prob_sum = '0;
`endif

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign argmax_idx   = res_idx_reg;
  assign argmax_val   = res_val_reg;
  assign elem_cnt     = res_cnt_reg;
  assign result_valid = result_valid_reg;
  assign len_err      = len_err_reg;
  assign overrun      = overrun_reg;
  assign busy         = (state_reg != IDLE);

endmodule

// File: tb/tb_softmax_argmax.sv
// -----------------------------------------------------------------------------
// tb_softmax_argmax
//
// Purpose:
//   Directed, self-checking bench for softmax_argmax. A behavioural model runs
//   alongside the stimulus; when a vector closes its expected result is pushed
//   to a scoreboard queue and popped when the DUT presents result_valid.
//   Expected prob_sum follows SOFTMAX_ARGMAX_SUM_EN (0 when undefined).
//
// Ports: none (top-level bench).
// -----------------------------------------------------------------------------
module tb_softmax_argmax;

  localparam int DW   = 24;
  localparam int IFM  = 1000;
  localparam int IW   = 10;
  localparam int SW   = 34;

  logic          clk1 = 1'b0;
  logic          rst;
  logic          valid_data;
  logic [DW-1:0] softmax_out_final;
  logic          end_softmax;
  logic          result_ack;
  logic [IW-1:0] argmax_idx;
  logic [DW-1:0] argmax_val;
  logic [SW-1:0] prob_sum;
  logic [IW:0]   elem_cnt;
  logic          result_valid;
  logic          len_err;
  logic          overrun;
  logic          busy;

  softmax_argmax #(
    .DATA_WIDTH_OUT(DW),
    .IFM_SIZE      (IFM),
    .IDX_WIDTH     (IW),
    .SUM_WIDTH     (SW)
  ) dut (
    .clk1             (clk1),
    .rst              (rst),
    .valid_data       (valid_data),
    .softmax_out_final(softmax_out_final),
    .end_softmax      (end_softmax),
    .result_ack       (result_ack),
    .argmax_idx       (argmax_idx),
    .argmax_val       (argmax_val),
    .prob_sum         (prob_sum),
    .elem_cnt         (elem_cnt),
    .result_valid     (result_valid),
    .len_err          (len_err),
    .overrun          (overrun),
    .busy             (busy)
  );

  always #5 clk1 = ~clk1;

  typedef struct {
    logic [IW-1:0] idx;
    logic [DW-1:0] val;
    logic [SW-1:0] sum;
    logic [IW:0]   cnt;
    logic          lerr;
  } exp_t;

  exp_t sb[$];
  exp_t last_exp;

  int n_vec  = 0;
  int n_fail = 0;

  // Model of the vector in progress.
  int            m_cnt = 0;
  logic [IW-1:0] m_idx;
  logic [DW-1:0] m_max;
  logic [SW-1:0] m_sum;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Drive one element for one clock and advance the model.
  task automatic feed_elem(input logic [DW-1:0] v, input logic e);
    exp_t x;
    valid_data        = 1'b1;
    softmax_out_final = v;
    end_softmax       = e;
    @(posedge clk1);
    #1;
    valid_data  = 1'b0;
    end_softmax = 1'b0;
    if (m_cnt == 0) begin
      m_max = v;
      m_idx = '0;
      m_sum = SW'(v);
      m_cnt = 1;
    end else begin
      if (v > m_max) begin
        m_max = v;
        m_idx = IW'(m_cnt);
      end
      m_sum = m_sum + SW'(v);
      m_cnt++;
    end
    if ((m_cnt == IFM) || e) begin
      x.idx  = m_idx;
      x.val  = m_max;
`ifdef SOFTMAX_ARGMAX_SUM_EN
      x.sum  = m_sum;
`else
      x.sum  = '0;
`endif
      x.cnt  = (IW+1)'(m_cnt);
      x.lerr = (m_cnt != IFM);
      sb.push_back(x);
      m_cnt = 0;
    end
  endtask

  task automatic check_fields(input string tag, input exp_t e);
    chk({tag, "_idx"},  64'(argmax_idx), 64'(e.idx));
    chk({tag, "_val"},  64'(argmax_val), 64'(e.val));
    chk({tag, "_sum"},  64'(prob_sum),   64'(e.sum));
    chk({tag, "_cnt"},  64'(elem_cnt),   64'(e.cnt));
    chk({tag, "_lerr"}, 64'(len_err),    64'(e.lerr));
  endtask

  // Called just after the closing edge: result_valid must already be up.
  task automatic check_result(input string tag);
    chk({tag, "_rvalid"}, 64'(result_valid), 64'd1);
    chk({tag, "_busy"},   64'(busy),         64'd1);
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 64'd0, 64'd1);
    end else begin
      last_exp = sb.pop_front();
      check_fields(tag, last_exp);
    end
  endtask

  task automatic ack_result(input string tag, input logic with_data);
    result_ack        = 1'b1;
    valid_data        = with_data;
    softmax_out_final = 24'hFFFFFF;
    @(posedge clk1);
    #1;
    result_ack = 1'b0;
    valid_data = 1'b0;
    chk({tag, "_ack_rvalid"}, 64'(result_valid), 64'd0);
    chk({tag, "_ack_busy"},   64'(busy),         64'd0);
    check_fields({tag, "_ack_keep"}, last_exp);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_idx"},     64'(argmax_idx),   64'd0);
    chk({tag, "_val"},     64'(argmax_val),   64'd0);
    chk({tag, "_sum"},     64'(prob_sum),     64'd0);
    chk({tag, "_cnt"},     64'(elem_cnt),     64'd0);
    chk({tag, "_rvalid"},  64'(result_valid), 64'd0);
    chk({tag, "_lerr"},    64'(len_err),      64'd0);
    chk({tag, "_overrun"}, 64'(overrun),      64'd0);
    chk({tag, "_busy"},    64'(busy),         64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst               = 1'b1;
    valid_data        = 1'b0;
    softmax_out_final = '0;
    end_softmax       = 1'b0;
    result_ack        = 1'b0;
    repeat (3) @(posedge clk1);
    #1;
    rst = 1'b0;
    check_all_zero("reset");

    // Ramp vector 0..999, closes on count.
    for (int i = 0; i < IFM - 1; i++) feed_elem(DW'(i), 1'b0);
    chk("ramp_pre_rvalid", 64'(result_valid), 64'd0);
    chk("ramp_pre_busy",   64'(busy),         64'd1);
    feed_elem(DW'(IFM - 1), 1'b0);
    check_result("ramp");
    repeat (3) @(posedge clk1);
    #1;
    chk("ramp_hold_rvalid", 64'(result_valid), 64'd1);
    check_fields("ramp_hold", last_exp);
    ack_result("ramp", 1'b0);

    // Flat vector with equal peaks at 5 and 700: earliest wins.
    for (int i = 0; i < IFM; i++)
      feed_elem((i == 5 || i == 700) ? 24'h7FFFFF : 24'h400000, 1'b0);
    check_result("peak");
    ack_result("peak", 1'b0);

    // Short vector closed by end_softmax alongside element 9.
    for (int i = 0; i < 10; i++) feed_elem(DW'(i * 3 + 1), (i == 9));
    check_result("short");

    // Data in HOLD is dropped and flags overrun.
    valid_data        = 1'b1;
    softmax_out_final = 24'hFFFFFF;
    @(posedge clk1);
    #1;
    valid_data = 1'b0;
    chk("ovr_flag",   64'(overrun),      64'd1);
    chk("ovr_rvalid", 64'(result_valid), 64'd1);
    check_fields("ovr_keep", last_exp);
    // Acknowledge with data in the same cycle: still dropped.
    ack_result("ovr", 1'b1);
    chk("ovr_sticky", 64'(overrun), 64'd1);

    // Stray result_ack and end_softmax in IDLE are ignored.
    result_ack  = 1'b1;
    end_softmax = 1'b1;
    @(posedge clk1);
    #1;
    result_ack  = 1'b0;
    end_softmax = 1'b0;
    chk("idle_stray_busy",   64'(busy),         64'd0);
    chk("idle_stray_rvalid", 64'(result_valid), 64'd0);

    // Next vector after overrun: ties keep earliest index.
    feed_elem(24'd7, 1'b0);
    feed_elem(24'd9, 1'b0);
    feed_elem(24'd9, 1'b1);
    check_result("tie");
    ack_result("tie", 1'b0);

    // Reset in the middle of a vector.
    for (int i = 0; i < 500; i++) feed_elem(DW'(i), 1'b0);
    rst               = 1'b1;
    valid_data        = 1'b1;
    softmax_out_final = 24'd500;
    @(posedge clk1);
    #1;
    rst        = 1'b0;
    valid_data = 1'b0;
    m_cnt      = 0;
    check_all_zero("midrst");

    // Full random vector after reset.
    for (int i = 0; i < IFM; i++) feed_elem(DW'($urandom & 32'h00FFFFFF), 1'b0);
    check_result("rand");
    ack_result("rand", 1'b0);

    chk("sb_drained", 64'(sb.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
